instr_sequencer: RTL and testbench

//  Program-ROM instruction sequencer feeding the FSM datapath: replaces the hard-coded per-step case

---
 rtl/sequencer_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 53 +++++
 rtl/instr_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_instr_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// Purpose: shared types and constants for the program-ROM instruction sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sequencer_pkg;

  localparam int INSTR_W = 16;

  // An all-zero program word marks the end of the program.
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } seq_state_t;

  function automatic logic is_halt_word(input logic [INSTR_W-1:0] word);
    return word == HALT_WORD;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose: synchronise a raw bouncing button, debounce it and emit a one-cycle pulse on each accepted rising edge.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1 cycle to the registered pulse.
// Backpressure: none; pulses are fire-and-forget and the consumer must take them in the cycle they appear.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has differed from the stable level for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      btn_rise <= 1'b0;
    end else begin
      btn_rise <= 1'b0;
      if (sync_q2 == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync_q2;
        cnt_q    <= '0;
        btn_rise <= sync_q2;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Purpose: loadable program ROM plus PC sequencer that issues one instruction word per step request to the FSM.
// Latency: step request in cycle t -> fetch in t+1 -> issue in t+2, FullOp/instr_valid registered at the end of t+2.
// Backpressure: none; one step request arriving mid-fetch/issue is held as pending, further ones are dropped.
module instr_sequencer
  import sequencer_pkg::*;
#(
  parameter int PROG_DEPTH      = 32,
  parameter int ADDR_W          = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RUN_DIV         = 8,
  parameter int RESET_STEPS     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_btn,
  input  logic               run_mode,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic [INSTR_W-1:0] FullOp,
  output logic [15:0]        imm,
  output logic               cpu_rst,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  localparam int DIV_W = $clog2(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam int RST_W = $clog2(RESET_STEPS + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_STEPS - 1);
  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(PROG_DEPTH - 1);

  seq_state_t         state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic               pending_q, pending_d;
  logic [ADDR_W-1:0]  pc_d;
  logic [15:0]        imm_d;
  logic [INSTR_W-1:0] full_op_d;
  logic               valid_d;
  logic               halted_d;
  logic               cpu_rst_d;

  logic               btn_rise;
  logic [DIV_W-1:0]   div_cnt_q;
  logic               div_tick;
  logic               step_req;
  logic               load_ok;

  logic [INSTR_W-1:0] prog_mem [PROG_DEPTH];
  logic [INSTR_W-1:0] rd_word;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (step_btn),
    .btn_rise (btn_rise)
  );

  // Auto-run divider: free-runs only in run mode so the first auto step is a
  // full RUN_DIV cycles after run_mode rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (!run_mode || div_cnt_q == DIV_LAST) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  assign div_tick = run_mode && (div_cnt_q == DIV_LAST);
  // In run mode the button is ignored entirely.
  assign step_req = run_mode ? div_tick : btn_rise;

  // Writes are only allowed while the sequencer is not reading the program.
  assign load_ok = load_en && (state_q == S_RESET || state_q == S_HALT);

  // Program memory write port; contents survive rst.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      prog_mem[load_addr] <= load_data;
    end
  end

  // Synchronous read port, addressed by the PC during the fetch cycle.
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH) begin
      rd_word <= prog_mem[pc];
    end
  end

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    pending_d = pending_q;
    pc_d      = pc;
    imm_d     = imm;
    full_op_d = FullOp;
    valid_d   = 1'b0;
    halted_d  = halted;
    cpu_rst_d = cpu_rst;

    case (state_q)
      S_RESET: begin
        cpu_rst_d = 1'b1;
        if (step_req) begin
          if (rst_cnt_q == RST_LAST) begin
            cpu_rst_d = 1'b0;
            state_d   = S_WAIT;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (step_req || pending_q) begin
          pending_d = 1'b0;
          state_d   = S_FETCH;
        end
      end

      S_FETCH: begin
        if (step_req) begin
          pending_d = 1'b1;
        end
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        if (step_req) begin
          pending_d = 1'b1;
        end
        if (is_halt_word(rd_word)) begin
          full_op_d = HALT_WORD;
          halted_d  = 1'b1;
          pending_d = 1'b0;
          state_d   = S_HALT;
        end else begin
          full_op_d = rd_word;
          valid_d   = 1'b1;
          imm_d     = imm + 16'd1;
          if (pc == PC_LAST) begin
            // Last program word: PC saturates rather than wrapping.
            halted_d  = 1'b1;
            pending_d = 1'b0;
            state_d   = S_HALT;
          end else begin
            pc_d    = pc + 1'b1;
            state_d = S_WAIT;
          end
        end
      end

      S_HALT: begin
        pending_d = 1'b0;
      end

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  // State and output registers; every output returns to its reset value as soon as rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET;
      rst_cnt_q   <= '0;
      pending_q   <= 1'b0;
      pc          <= '0;
      imm         <= '0;
      FullOp      <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      cpu_rst     <= 1'b1;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      pending_q   <= pending_d;
      pc          <= pc_d;
      imm         <= imm_d;
      FullOp      <= full_op_d;
      instr_valid <= valid_d;
      halted      <= halted_d;
      cpu_rst     <= cpu_rst_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Purpose: directed self-checking bench for instr_sequencer with a scoreboard of expected issues.
// Latency: n/a.
// Backpressure: n/a.
module tb_instr_sequencer;
  import sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_btn = 1'b0;
  logic        run_mode = 1'b0;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic [15:0] FullOp;
  logic [15:0] imm;
  logic        cpu_rst;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        halted;

  instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .step_btn    (step_btn),
    .run_mode    (run_mode),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .FullOp      (FullOp),
    .imm         (imm),
    .cpu_rst     (cpu_rst),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] op;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vtimes[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc++;

  // Monitor: every issued instruction is popped against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && instr_valid) begin
      vtimes.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_issue: FullOp=%h imm=%0d, no issue expected", FullOp, imm);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (FullOp !== e.op) begin
          n_err++;
          $display("FAIL issue_FullOp: got %h expected %h", FullOp, e.op);
        end
        n_cmp++;
        if (imm !== e.cnt) begin
          n_err++;
          $display("FAIL issue_imm: got %0d expected %0d", imm, e.cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic expect_issue(input logic [15:0] op, input logic [15:0] cnt);
    exp_t e;
    e.op  = op;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_FullOp"},  32'(FullOp), 32'h0);
    chk({tag, "_imm"},     32'(imm), 32'h0);
    chk({tag, "_pc"},      32'(pc), 32'h0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'h1);
    chk({tag, "_halted"},  32'(halted), 32'h0);
    chk({tag, "_valid"},   32'(instr_valid), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    run_mode = 1'b0;
    step_btn = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_word(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic press();
    step_btn = 1'b1;
    repeat (24) @(posedge clk);
    step_btn = 1'b0;
    repeat (24) @(posedge clk);
  endtask

  task automatic wait_halt(input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk({tag, "_halted"}, 32'(halted), 32'h1);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_scoreboard_left"}, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    // Test 1/2: reset values, then a short program stepped by button.
    do_reset();
    load_word(5'd0, 16'h5100);
    load_word(5'd1, 16'h0250);
    load_word(5'd2, 16'h0000);
    press();
    @(negedge clk);
    chk("t2_cpu_rst_after_1step", 32'(cpu_rst), 32'h1);
    press();
    @(negedge clk);
    chk("t2_cpu_rst_after_2steps", 32'(cpu_rst), 32'h0);
    chk("t2_pc_before_fetch", 32'(pc), 32'h0);
    expect_issue(16'h5100, 16'd1);
    press();
    @(negedge clk);
    chk("t2_pc_after_1st", 32'(pc), 32'h1);
    chk("t2_FullOp_hold_1st", 32'(FullOp), 32'h5100);
    expect_issue(16'h0250, 16'd2);
    press();
    @(negedge clk);
    chk("t2_imm_after_2nd", 32'(imm), 32'd2);
    press();
    @(negedge clk);
    chk("t2_halted", 32'(halted), 32'h1);
    chk("t2_FullOp_halt", 32'(FullOp), 32'h0);
    chk("t2_imm_halt", 32'(imm), 32'd2);
    chk_drained("t2");

    // Test 3: bouncing button yields exactly one step.
    do_reset();
    load_word(5'd0, 16'h1234);
    load_word(5'd1, 16'h5678);
    press();
    press();
    expect_issue(16'h1234, 16'd1);
    for (int i = 0; i < 5; i++) begin
      step_btn = ~step_btn;
      repeat (3) @(posedge clk);
    end
    repeat (40) @(posedge clk);
    step_btn = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("t3_pc", 32'(pc), 32'h1);
    chk_drained("t3");

    // Test 4: run mode, four words then HALT, pulses RUN_DIV apart.
    do_reset();
    load_word(5'd0, 16'h1111);
    load_word(5'd1, 16'h2222);
    load_word(5'd2, 16'h3333);
    load_word(5'd3, 16'h4444);
    load_word(5'd4, 16'h0000);
    expect_issue(16'h1111, 16'd1);
    expect_issue(16'h2222, 16'd2);
    expect_issue(16'h3333, 16'd3);
    expect_issue(16'h4444, 16'd4);
    vtimes.delete();
    @(negedge clk);
    run_mode = 1'b1;
    wait_halt(300, "t4");
    repeat (20) @(negedge clk);
    run_mode = 1'b0;
    chk("t4_issue_count", 32'(vtimes.size()), 32'd4);
    if (vtimes.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("t4_spacing", 32'(vtimes[i] - vtimes[i-1]), 32'd8);
    end
    chk("t4_FullOp", 32'(FullOp), 32'h0);
    chk("t4_imm", 32'(imm), 32'd4);
    chk_drained("t4");

    // Test 5: full 32-word program runs to PC saturation.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      load_word(5'(i), 16'h8000 + 16'(i));
      expect_issue(16'h8000 + 16'(i), 16'(i + 1));
    end
    vtimes.delete();
    @(negedge clk);
    run_mode = 1'b1;
    wait_halt(1000, "t5");
    repeat (50) @(negedge clk);
    chk("t5_issue_count", 32'(vtimes.size()), 32'd32);
    chk("t5_imm", 32'(imm), 32'd32);
    chk("t5_pc", 32'(pc), 32'd31);
    chk("t5_FullOp_last", 32'(FullOp), 32'h801F);
    chk("t5_cpu_rst", 32'(cpu_rst), 32'h0);
    run_mode = 1'b0;
    chk_drained("t5");

    // Test 6: load in S_WAIT ignored; reset during S_ISSUE then rerun.
    do_reset();
    load_word(5'd0, 16'h00A1);
    load_word(5'd1, 16'h00B2);
    load_word(5'd2, 16'h00C3);
    load_word(5'd3, 16'h0000);
    press();
    press();
    load_word(5'd1, 16'hDEAD);
    expect_issue(16'h00A1, 16'd1);
    press();
    expect_issue(16'h00B2, 16'd2);
    press();
    expect_issue(16'h00C3, 16'd3);
    press();
    press();
    @(negedge clk);
    chk("t6_halted_first", 32'(halted), 32'h1);
    chk_drained("t6a");

    do_reset();
    press();
    press();
    step_btn = 1'b1;
    begin : find_issue
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (dut.state_q == S_ISSUE) disable find_issue;
      end
    end
    chk("t6_reached_issue", 32'(dut.state_q == S_ISSUE), 32'h1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_mid_issue_rst");
    step_btn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_issue(16'h00A1, 16'd1);
    expect_issue(16'h00B2, 16'd2);
    expect_issue(16'h00C3, 16'd3);
    @(negedge clk);
    run_mode = 1'b1;
    wait_halt(300, "t6_rerun");
    run_mode = 1'b0;
    chk("t6_rerun_FullOp", 32'(FullOp), 32'h0);
    chk("t6_rerun_imm", 32'(imm), 32'd3);
    chk_drained("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
